// File: rtl/instr_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Processor-wide fetch definitions shared by the fetch unit and its queue:
//   INSN_NOP          - canonical NOP (addi x0,x0,0) shown when nothing is valid
//   DEFAULT_RESET_PC  - default program counter after reset
//   fetch_entry_t     - one queue entry: instruction word plus its address
//   word_align()      - clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  localparam logic [31:0] INSN_NOP         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Small synchronous FIFO holding fetched {pc, instruction} pairs.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   push, push_data - write one 64-bit entry
//   pop          - remove the head entry (ignored when empty)
//   flush        - discard every entry; wins over push and pop
//   head         - current head entry (meaningful only when count != 0)
//   count        - occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [63:0]              push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [63:0]              head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full queue is allowed only when the head leaves the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Front-end fetch stage: owns the PC, issues in-order word reads to
// instruction memory, buffers returned words and presents them to decode.
// A redirect reloads the PC, flushes the queue and discards in-flight words.
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   imem_req_valid/ready/addr      - fetch request channel (word aligned)
//   imem_rsp_valid/data            - in-order response channel, no backpressure
//   redirect_valid/pc              - single-cycle PC reload from execute
//   dec_valid/ready                - decode handshake
//   instruction_code, dec_pc       - head instruction and its address
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] instruction_code,
  output logic [31:0] dec_pc
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  // Repeated redirects can stack several generations of stale responses,
  // so the drop counter gets generous headroom beyond one queue's worth.
  localparam int DW = CW + 6;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(QUEUE_DEPTH);

  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] occ;
  logic [CW-1:0] outst;
  logic [DW-1:0] drop;
  logic [31:0]   target;
  logic          credit;
  logic          req_fire;
  logic          rsp_keep;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  assign target = word_align(redirect_pc);

  // Every outstanding request already owns a queue slot, so responses can
  // never be refused. Reset gates the request so nothing is issued while low.
  assign credit         = ({1'b0, occ} + {1'b0, outst}) < DEPTH_C;
  assign imem_req_valid = rst_n && !redirect_valid && credit;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses are in order and stale ones always precede live ones, so the
  // PC of the next live response is tracked by a single running counter.
  assign rsp_keep   = imem_rsp_valid && (drop == '0);
  assign push       = rsp_keep && !redirect_valid;
  assign pop        = dec_valid && dec_ready;
  assign push_entry = '{pc: rsp_pc, insn: imem_rsp_data};

  // PC, outstanding-request and stale-response bookkeeping. On a redirect
  // every request still in flight becomes stale, minus the one answered now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      rsp_pc <= RESET_PC;
      outst  <= '0;
      drop   <= '0;
    end else if (redirect_valid) begin
      pc     <= target;
      rsp_pc <= target;
      outst  <= '0;
      drop   <= drop + DW'(outst) - DW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc <= pc + 32'd4;
      if (rsp_keep) rsp_pc <= rsp_pc + 32'd4;
      outst <= outst + CW'(req_fire) - CW'(rsp_keep);
      if (imem_rsp_valid && (drop != '0)) drop <= drop - DW'(1);
    end
  end

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect_valid),
    .head     (head_entry),
    .count    (occ)
  );

  assign dec_valid        = (occ != '0);
  assign instruction_code = dec_valid ? head_entry.insn : INSN_NOP;
  assign dec_pc           = dec_valid ? head_entry.pc : 32'h0000_0000;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit with an in-order memory model whose
// latency is adjustable. Memory returns the bitwise inverse of the address,
// so every expected instruction word follows from its expected PC.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] instruction_code;
  logic [31:0] dec_pc;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .QUEUE_DEPTH(2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .instruction_code(instruction_code),
    .dec_pc          (dec_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    int               lat;
    int               redir_at;
    logic [31:0]      target;
    logic [3:0][31:0] exp_pc;
  } scen_t;

  mreq_t       mq[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_insn[$];
  logic [31:0] req_log[$];
  int          cyc;
  int          lat;
  int          vectors;
  int          miscompares;

  // Memory model: a request seen in cycle c answers in cycle c+lat.
  initial begin
    cyc            = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (!rst_n) begin
        mq.delete();
        imem_rsp_valid = 1'b0;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~mq[0].addr;
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // Handshake monitor: records issued requests and consumed instructions.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && imem_req_valid && imem_req_ready) begin
        mq.push_back('{addr: imem_req_addr, due: cyc + lat});
        req_log.push_back(imem_req_addr);
      end
      if (rst_n && dec_valid && dec_ready) begin
        got_pc.push_back(dec_pc);
        got_insn.push_back(instruction_code);
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Resets the DUT, then runs ncyc cycles with an optional one-cycle redirect.
  task automatic apply_stimulus(input int l, input int ra, input logic [31:0] tgt,
                                input int ncyc, input logic rdy);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = rdy;
    lat            = l;
    repeat (2) @(posedge clk);
    #1;
    got_pc.delete();
    got_insn.delete();
    req_log.delete();
    rst_n = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      redirect_valid = (k == ra);
      redirect_pc    = tgt;
      @(posedge clk);
      #1;
    end
    redirect_valid = 1'b0;
  endtask

  task automatic check_decodes(input string name, input logic [3:0][31:0] exp);
    vectors = vectors + 1;
    if (got_pc.size() < 4) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s count: got %0d decodes, expected at least 4", name, got_pc.size());
    end
    for (int j = 0; j < 4; j++) begin
      if (j < got_pc.size()) begin
        check_output($sformatf("%s pc%0d", name, j), got_pc[j], exp[j]);
        check_output($sformatf("%s insn%0d", name, j), got_insn[j], ~exp[j]);
      end
    end
  endtask

  scen_t tab[6];

  initial begin
    vectors        = 0;
    miscompares    = 0;
    lat            = 1;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b1;

    // lat, redirect cycle (-1 none), target, first four decoded PCs
    tab[0] = '{1, -1, 32'h0,         '{32'h0000_000C, 32'h0000_0008, 32'h0000_0004, 32'h0000_0000}};
    tab[1] = '{3,  2, 32'h100,       '{32'h0000_010C, 32'h0000_0108, 32'h0000_0104, 32'h0000_0100}};
    tab[2] = '{1,  3, 32'h200,       '{32'h0000_0204, 32'h0000_0200, 32'h0000_0004, 32'h0000_0000}};
    tab[3] = '{1,  1, 32'hFFFF_FFFE, '{32'h0000_0008, 32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFC}};
    tab[4] = '{1,  2, 32'h43,        '{32'h0000_0048, 32'h0000_0044, 32'h0000_0040, 32'h0000_0000}};
    tab[5] = '{3,  3, 32'h80,        '{32'h0000_008C, 32'h0000_0088, 32'h0000_0084, 32'h0000_0080}};

    // Reset values and the first request after release.
    repeat (2) @(negedge clk);
    check_output("reset dec_valid", {31'h0, dec_valid}, 32'h0);
    check_output("reset insn", instruction_code, 32'h0000_0013);
    check_output("reset dec_pc", dec_pc, 32'h0);
    check_output("reset req_valid", {31'h0, imem_req_valid}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_output("first req_valid", {31'h0, imem_req_valid}, 32'h1);
    check_output("first req_addr", imem_req_addr, 32'h0);

    // Table-driven scenarios.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(tab[i].lat, tab[i].redir_at, tab[i].target, 30, 1'b1);
      check_decodes($sformatf("scen%0d", i), tab[i].exp_pc);
      if (i == 0) begin
        for (int j = 0; j < 4; j++)
          check_output($sformatf("scen0 req%0d", j), (j < req_log.size()) ? req_log[j] : 32'hDEAD_BEEF, 32'(4 * j));
      end
      if (i == 3) begin
        check_output("wrap req1", (req_log.size() > 1) ? req_log[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check_output("wrap req2", (req_log.size() > 2) ? req_log[2] : 32'hDEAD_BEEF, 32'h0000_0000);
      end
      if (i >= 4) check_output($sformatf("scen%0d drop", i), 32'(dut.drop), 32'h0);
    end

    // Decode stalled for 10 cycles: queue fills and requests stop.
    apply_stimulus(1, -1, 32'h0, 10, 1'b0);
    @(negedge clk);
    check_output("stall req count", 32'(req_log.size()), 32'd2);
    check_output("stall req_valid", {31'h0, imem_req_valid}, 32'h0);
    check_output("stall dec_valid", {31'h0, dec_valid}, 32'h1);
    check_output("stall dec_pc", dec_pc, 32'h0);
    @(posedge clk);
    #1;
    dec_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_decodes("drain", '{32'h0000_000C, 32'h0000_0008, 32'h0000_0004, 32'h0000_0000});

    // Reset asserted mid-cycle with a word queued and a request in flight.
    apply_stimulus(3, -1, 32'h0, 4, 1'b0);
    check_output("pre-reset dec_valid", {31'h0, dec_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid-reset dec_valid", {31'h0, dec_valid}, 32'h0);
    check_output("mid-reset insn", instruction_code, 32'h0000_0013);
    check_output("mid-reset dec_pc", dec_pc, 32'h0);
    check_output("mid-reset req_valid", {31'h0, imem_req_valid}, 32'h0);
    check_output("mid-reset outst", 32'(dut.outst), 32'h0);
    apply_stimulus(1, -1, 32'h0, 12, 1'b1);
    check_output("restart req0", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, 32'h0);
    check_decodes("restart", '{32'h0000_000C, 32'h0000_0008, 32'h0000_0004, 32'h0000_0000});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
